// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for load_store_unit.
// The slave modport is the unit itself; master is the requester/memory side.
interface load_store_unit_if #(
    parameter int n = 64
);
    logic         ReqValid;
    logic         ReqReady;
    logic         ReqWrite;
    logic [n-1:0] ReqAddr;
    logic [n-1:0] ReqData;
    logic [1:0]   ReqSize;
    logic         ReqSigned;
    logic [n-1:0] MemAddress;
    logic [n-1:0] MemWriteData;
    logic         MemoryRead;
    logic         MemoryWrite;
    logic [n-1:0] MemReadData;
    logic         RspValid;
    logic [n-1:0] RspData;
    logic         RspErr;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqData, ReqSize, ReqSigned, MemReadData,
        input  ReqReady, MemAddress, MemWriteData, MemoryRead, MemoryWrite,
               RspValid, RspData, RspErr
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqData, ReqSize, ReqSigned, MemReadData,
        output ReqReady, MemAddress, MemWriteData, MemoryRead, MemoryWrite,
               RspValid, RspData, RspErr
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word/doubleword load-store unit over a doubleword-wide data memory.
// Sub-doubleword stores are done as read-modify-write; all outputs are registered.
module load_store_unit #(
    parameter int n        = 64,
    parameter int READ_LAT = 1
) (
    input  logic             Clock,
    input  logic             ResetL,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [1:0]   LAST_RD = 2'(READ_LAT - 1);
    localparam logic [n-1:0] ONES    = '1;

    state_t       state, state_nxt;
    logic [1:0]   rd_cnt;

    logic         req_write;
    logic [2:0]   req_off;
    logic [n-1:0] req_data;
    logic [1:0]   req_size;
    logic         req_signed;

    logic         accept;
    logic         misaligned;
    logic [2:0]   align_mask;
    logic         rd_done;

    logic         ready_d, mrd_d, mwr_d, rspv_d, rsperr_d;
    logic [n-1:0] maddr_d, mwdata_d, rspdata_d;
    logic [n-1:0] lanes, lane_mask, shifted, load_val, merged;

    assign accept  = (state == IDLE) && bus.ReqValid && bus.ReqReady;
    assign rd_done = (state == RD) && (rd_cnt == LAST_RD);

    always_comb begin
        case (bus.ReqSize)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        misaligned = (bus.ReqAddr[2:0] & align_mask) != 3'b000;
    end

    // Lane arithmetic works on the registered request: only meaningful in RD.
    always_comb begin
        lanes     = ONES >> (n - (8 << req_size));
        lane_mask = lanes << {req_off, 3'b000};
        shifted   = bus.MemReadData >> {req_off, 3'b000};
        merged    = (bus.MemReadData & ~lane_mask) | ((req_data << {req_off, 3'b000}) & lane_mask);
        case (req_size)
            2'b00:   load_val = req_signed ? {{(n-8){shifted[7]}}, shifted[7:0]}
                                           : {{(n-8){1'b0}}, shifted[7:0]};
            2'b01:   load_val = req_signed ? {{(n-16){shifted[15]}}, shifted[15:0]}
                                           : {{(n-16){1'b0}}, shifted[15:0]};
            2'b10:   load_val = req_signed ? {{(n-32){shifted[31]}}, shifted[31:0]}
                                           : {{(n-32){1'b0}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetL) begin
            state            <= IDLE;
            rd_cnt           <= '0;
            bus.ReqReady     <= 1'b0;
            bus.MemoryRead   <= 1'b0;
            bus.MemoryWrite  <= 1'b0;
            bus.RspValid     <= 1'b0;
            bus.RspErr       <= 1'b0;
            bus.MemAddress   <= '0;
            bus.MemWriteData <= '0;
            bus.RspData      <= '0;
        end else begin
            state            <= state_nxt;
            rd_cnt           <= (state == RD) ? rd_cnt + 2'd1 : '0;
            bus.ReqReady     <= ready_d;
            bus.MemoryRead   <= mrd_d;
            bus.MemoryWrite  <= mwr_d;
            bus.RspValid     <= rspv_d;
            bus.RspErr       <= rsperr_d;
            bus.MemAddress   <= maddr_d;
            bus.MemWriteData <= mwdata_d;
            bus.RspData      <= rspdata_d;
            if (accept) begin
                req_write  <= bus.ReqWrite;
                req_off    <= bus.ReqAddr[2:0];
                req_data   <= bus.ReqData;
                req_size   <= bus.ReqSize;
                req_signed <= bus.ReqSigned;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)
                        state_nxt = RESP;
                    else if (bus.ReqWrite && bus.ReqSize == 2'b11)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD:   if (rd_cnt == LAST_RD) state_nxt = req_write ? WR : RESP;
            WR:   state_nxt = RESP;
            RESP: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state, so the strobes line up with it.
    always_comb begin
        ready_d   = (state_nxt == IDLE);
        mrd_d     = (state_nxt == RD);
        mwr_d     = (state_nxt == WR);
        rspv_d    = (state_nxt == RESP);
        rsperr_d  = 1'b0;
        rspdata_d = '0;
        maddr_d   = bus.MemAddress;
        mwdata_d  = bus.MemWriteData;
        if (accept) begin
            maddr_d  = bus.ReqAddr >> 3;
            rsperr_d = misaligned;
            if (bus.ReqWrite) mwdata_d = bus.ReqData;
        end
        if (rd_done) begin
            if (req_write) mwdata_d  = merged;
            else           rspdata_d = load_val;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: two instances (read latency 1 and 3)
// share one byte-addressed memory and one byte-level reference model.
module tb_load_store_unit;
    localparam int N = 64;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passed = 0;

    bit          sel = 1'b0;
    logic        rq_valid = 1'b0;
    logic        rq_write = 1'b0;
    logic [N-1:0] rq_addr = '0;
    logic [N-1:0] rq_data = '0;
    logic [1:0]  rq_size = '0;
    logic        rq_signed = 1'b0;
    logic [N-1:0] mrdata;

    load_store_unit_if #(.n(N)) lsu1 ();
    load_store_unit_if #(.n(N)) lsu3 ();

    load_store_unit #(.n(N), .READ_LAT(1)) u_dut1 (.Clock(clk), .ResetL(rst_l), .bus(lsu1));
    load_store_unit #(.n(N), .READ_LAT(3)) u_dut3 (.Clock(clk), .ResetL(rst_l), .bus(lsu3));

    assign lsu1.ReqValid    = rq_valid & ~sel;
    assign lsu3.ReqValid    = rq_valid & sel;
    assign lsu1.ReqWrite    = rq_write;
    assign lsu3.ReqWrite    = rq_write;
    assign lsu1.ReqAddr     = rq_addr;
    assign lsu3.ReqAddr     = rq_addr;
    assign lsu1.ReqData     = rq_data;
    assign lsu3.ReqData     = rq_data;
    assign lsu1.ReqSize     = rq_size;
    assign lsu3.ReqSize     = rq_size;
    assign lsu1.ReqSigned   = rq_signed;
    assign lsu3.ReqSigned   = rq_signed;
    assign lsu1.MemReadData = mrdata;
    assign lsu3.MemReadData = mrdata;

    logic         t_ready, t_mrd, t_mwr, t_rspv, t_rsperr;
    logic [N-1:0] t_maddr, t_mwdata, t_rspdata;
    assign t_ready   = sel ? lsu3.ReqReady     : lsu1.ReqReady;
    assign t_mrd     = sel ? lsu3.MemoryRead   : lsu1.MemoryRead;
    assign t_mwr     = sel ? lsu3.MemoryWrite  : lsu1.MemoryWrite;
    assign t_rspv    = sel ? lsu3.RspValid     : lsu1.RspValid;
    assign t_rsperr  = sel ? lsu3.RspErr       : lsu1.RspErr;
    assign t_maddr   = sel ? lsu3.MemAddress   : lsu1.MemAddress;
    assign t_mwdata  = sel ? lsu3.MemWriteData : lsu1.MemWriteData;
    assign t_rspdata = sel ? lsu3.RspData      : lsu1.RspData;

    // Memory device seen by the DUT; data is only valid in the last cycle of a read burst.
    logic [7:0]  dev_b [0:127];
    logic [7:0]  ref_b [0:127];
    int unsigned rdcnt = 0;

    always @(posedge clk) rdcnt <= t_mrd ? rdcnt + 1 : 0;

    always @(posedge clk)
        if (t_mwr)
            for (int unsigned i = 0; i < 8; i++)
                dev_b[int'(t_maddr[3:0]) * 8 + int'(i)] <= t_mwdata[8*i +: 8];

    always_comb begin
        mrdata = 64'hDEAD_BEEF_0BAD_F00D;
        if (t_mrd && rdcnt == (sel ? 32'd2 : 32'd0))
            for (int unsigned i = 0; i < 8; i++)
                mrdata[8*i +: 8] = dev_b[int'(t_maddr[3:0]) * 8 + int'(i)];
    end

    function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] size, input bit sgn);
        int unsigned nb = 32'd1 << size;
        logic [63:0] v = '0;
        for (int unsigned i = 0; i < nb; i++) v[8*i +: 8] = ref_b[int'(addr[6:0]) + int'(i)];
        if (sgn && nb < 8 && v[8*nb-1])
            for (int unsigned i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic void ref_store(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size);
        int unsigned nb = 32'd1 << size;
        for (int unsigned i = 0; i < nb; i++) ref_b[int'(addr[6:0]) + int'(i)] = data[8*i +: 8];
    endfunction

    function automatic logic [63:0] ref_dword(input logic [3:0] idx);
        logic [63:0] v;
        for (int unsigned i = 0; i < 8; i++) v[8*i +: 8] = ref_b[int'(idx) * 8 + int'(i)];
        return v;
    endfunction

    function automatic logic [63:0] dev_dword(input logic [3:0] idx);
        logic [63:0] v;
        for (int unsigned i = 0; i < 8; i++) v[8*i +: 8] = dev_b[int'(idx) * 8 + int'(i)];
        return v;
    endfunction

    task automatic run_txn(input bit wr, input logic [63:0] addr, input logic [63:0] data,
                           input logic [1:0] size, input bit sgn, input string tag,
                           output logic [63:0] got_rsp, output logic [63:0] got_w);
        int unsigned nb = 32'd1 << size;
        bit mis = (addr % 64'(nb)) != 0;
        int unsigned lat = sel ? 3 : 1;
        int unsigned exp_rd = (!mis && (!wr || size != 2'b11)) ? lat : 0;
        int unsigned exp_wr = (!mis && wr) ? 1 : 0;
        logic [63:0] exp_rsp = '0;
        logic [63:0] exp_w = '0;
        int unsigned waits = 0, cyc = 0, nrd = 0, nwr = 0;
        bit order_bad = 0, addr_bad = 0, busy_bad = 0;
        got_rsp = '0;
        got_w   = '0;
        if (!mis && !wr) exp_rsp = ref_load(addr, size, sgn);
        if (!mis && wr) begin
            ref_store(addr, data, size);
            exp_w = ref_dword(addr[6:3]);
        end
        rq_write = wr; rq_addr = addr; rq_data = data; rq_size = size; rq_signed = sgn;
        rq_valid = 1'b1;
        while (t_ready !== 1'b1 && waits < 20) begin @(negedge clk); waits++; end
        checks++;
        if (t_ready !== 1'b1) $display("FAIL %s accept: ReqReady=%b required 1", tag, t_ready);
        else passed++;
        @(negedge clk);
        rq_valid = 1'b0;
        while (t_rspv !== 1'b1 && cyc < 20) begin
            if (t_mrd === 1'b1) begin nrd++; if (nwr != 0) order_bad = 1; end
            if (t_mwr === 1'b1) begin nwr++; got_w = t_mwdata; end
            if (t_mrd === 1'b1 && t_mwr === 1'b1) order_bad = 1;
            if ((t_mrd === 1'b1 || t_mwr === 1'b1) && t_maddr !== (addr >> 3)) addr_bad = 1;
            if (t_ready !== 1'b0) busy_bad = 1;
            @(negedge clk); cyc++;
        end
        if (t_ready !== 1'b0 || t_mrd !== 1'b0 || t_mwr !== 1'b0) busy_bad = 1;
        got_rsp = t_rspdata;

        checks++;
        if (t_rspv !== 1'b1 || cyc != exp_rd + exp_wr)
            $display("FAIL %s latency: RspValid=%b after %0d cycles required 1 after %0d", tag, t_rspv, cyc, exp_rd + exp_wr);
        else passed++;
        checks++;
        if (t_rsperr !== mis) $display("FAIL %s rsperr: got %b required %b", tag, t_rsperr, mis);
        else passed++;
        checks++;
        if (t_rspdata !== exp_rsp) $display("FAIL %s rspdata: got %h required %h", tag, t_rspdata, exp_rsp);
        else passed++;
        checks++;
        if (nrd != exp_rd) $display("FAIL %s read_cycles: got %0d required %0d", tag, nrd, exp_rd);
        else passed++;
        checks++;
        if (nwr != exp_wr) $display("FAIL %s write_cycles: got %0d required %0d", tag, nwr, exp_wr);
        else passed++;
        checks++;
        if (order_bad) $display("FAIL %s strobe_order: overlap/reversal got 1 required 0", tag);
        else passed++;
        checks++;
        if (addr_bad) $display("FAIL %s memaddress: unstable or wrong, required %h", tag, addr >> 3);
        else passed++;
        checks++;
        if (busy_bad) $display("FAIL %s busy: ReqReady/strobe active while busy, required 0", tag);
        else passed++;
        if (wr && !mis) begin
            checks++;
            if (got_w !== exp_w) $display("FAIL %s memwritedata: got %h required %h", tag, got_w, exp_w);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (t_rspv !== 1'b0 || t_ready !== 1'b1)
            $display("FAIL %s after_resp: RspValid=%b ReqReady=%b required 0 1", tag, t_rspv, t_ready);
        else passed++;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lsu1.ReqReady, lsu1.MemoryRead, lsu1.MemoryWrite, lsu1.RspValid, lsu1.RspErr} !== 5'b0 ||
            lsu1.MemAddress !== '0 || lsu1.MemWriteData !== '0 || lsu1.RspData !== '0)
            $display("FAIL reset_lat1: outputs not all 0, ReqReady=%b MemAddress=%h", lsu1.ReqReady, lsu1.MemAddress);
        else passed++;
        checks++;
        if ({lsu3.ReqReady, lsu3.MemoryRead, lsu3.MemoryWrite, lsu3.RspValid, lsu3.RspErr} !== 5'b0 ||
            lsu3.MemAddress !== '0 || lsu3.MemWriteData !== '0 || lsu3.RspData !== '0)
            $display("FAIL reset_lat3: outputs not all 0, ReqReady=%b MemAddress=%h", lsu3.ReqReady, lsu3.MemAddress);
        else passed++;
        rst_l = 1'b1;
        @(negedge clk);
        checks++;
        if (lsu1.ReqReady !== 1'b1 || lsu3.ReqReady !== 1'b1)
            $display("FAIL reset_release: ReqReady=%b/%b required 1/1", lsu1.ReqReady, lsu3.ReqReady);
        else passed++;
    endtask

    task automatic test_dword_load();
        logic [63:0] r, w;
        sel = 1'b0;
        run_txn(1'b0, 64'h18, 64'h0, 2'b11, 1'b0, "dw_load", r, w);
        checks++;
        if (r !== 64'h8877665544332211) $display("FAIL dw_load_value: got %h required 8877665544332211", r);
        else passed++;
    endtask

    task automatic test_byte_load();
        logic [63:0] r, w;
        sel = 1'b0;
        run_txn(1'b0, 64'h1F, 64'h0, 2'b00, 1'b1, "byte_signed", r, w);
        checks++;
        if (r !== 64'hFFFFFFFFFFFFFF88) $display("FAIL byte_signed_value: got %h required ffffffffffffff88", r);
        else passed++;
        run_txn(1'b0, 64'h1F, 64'h0, 2'b00, 1'b0, "byte_unsigned", r, w);
        checks++;
        if (r !== 64'h88) $display("FAIL byte_unsigned_value: got %h required 88", r);
        else passed++;
    endtask

    task automatic test_half_store();
        logic [63:0] r, w;
        sel = 1'b0;
        run_txn(1'b1, 64'h1A, 64'hBEEF, 2'b01, 1'b0, "half_store", r, w);
        checks++;
        if (w !== 64'h88776655BEEF2211) $display("FAIL half_store_wdata: got %h required 88776655beef2211", w);
        else passed++;
        checks++;
        if (r !== 64'h0) $display("FAIL half_store_rspdata: got %h required 0", r);
        else passed++;
        run_txn(1'b0, 64'h18, 64'h0, 2'b11, 1'b0, "half_store_readback", r, w);
        checks++;
        if (r !== 64'h88776655BEEF2211) $display("FAIL half_store_readback_value: got %h required 88776655beef2211", r);
        else passed++;
    endtask

    task automatic test_misaligned();
        logic [63:0] r, w;
        sel = 1'b0;
        run_txn(1'b0, 64'h1E, 64'h0, 2'b10, 1'b0, "misaligned_word_load", r, w);
        run_txn(1'b1, 64'h1C, 64'h1234_5678_9ABC_DEF0, 2'b11, 1'b0, "misaligned_dw_store", r, w);
        sel = 1'b1;
        run_txn(1'b0, 64'h21, 64'h0, 2'b01, 1'b1, "misaligned_half_lat3", r, w);
    endtask

    task automatic test_random(input bit which, input int unsigned count);
        logic [63:0] r, w, addr, data;
        logic [1:0]  size;
        bit          wr, sgn;
        sel = which;
        for (int unsigned k = 0; k < count; k++) begin
            wr   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = 64'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'((32'd1 << size) - 1);
            data = {$urandom(), $urandom()};
            run_txn(wr, addr, data, size, sgn, which ? "random_lat3" : "random_lat1", r, w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bit          wr_q [4];
        bit          sg_q [4];
        bit          mis_q [4];
        logic [63:0] ad_q [4];
        logic [63:0] dt_q [4];
        logic [63:0] exp_q [4];
        logic [1:0]  sz_q [4];
        int unsigned lat_q [4];
        int unsigned acc_cyc [4];
        int unsigned n_acc = 0, n_rsp = 0, cyc = 0, last_rsp = 0, extra = 0;
        sel  = 1'b1;
        wr_q = '{1'b0, 1'b0, 1'b1, 1'b0};
        sg_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        ad_q = '{64'h20, 64'h23, 64'h21, 64'h21};
        sz_q = '{2'b10, 2'b01, 2'b00, 2'b00};
        dt_q = '{64'h0, 64'h0, 64'($urandom_range(128, 255)), 64'h0};
        for (int unsigned k = 0; k < 4; k++) begin
            mis_q[k]   = (ad_q[k] % 64'(32'd1 << sz_q[k])) != 0;
            acc_cyc[k] = 0;
            exp_q[k]   = '0;
            if (mis_q[k])                 lat_q[k] = 1;
            else if (!wr_q[k])            lat_q[k] = 3 + 1;
            else if (sz_q[k] == 2'b11)    lat_q[k] = 2;
            else                          lat_q[k] = 3 + 2;
            if (!mis_q[k] && !wr_q[k]) exp_q[k] = ref_load(ad_q[k], sz_q[k], sg_q[k]);
            if (!mis_q[k] && wr_q[k])  ref_store(ad_q[k], dt_q[k], sz_q[k]);
        end
        rq_write = wr_q[0]; rq_addr = ad_q[0]; rq_data = dt_q[0]; rq_size = sz_q[0]; rq_signed = sg_q[0];
        rq_valid = 1'b1;
        while (n_rsp < 4 && cyc < 60) begin
            if (t_rspv === 1'b1) begin
                checks++;
                if (t_rspdata !== exp_q[n_rsp] || t_rsperr !== mis_q[n_rsp])
                    $display("FAIL b2b_rsp%0d: data=%h err=%b required %h %b", n_rsp, t_rspdata, t_rsperr, exp_q[n_rsp], mis_q[n_rsp]);
                else passed++;
                checks++;
                if (cyc - acc_cyc[n_rsp] != lat_q[n_rsp])
                    $display("FAIL b2b_latency%0d: got %0d required %0d", n_rsp, cyc - acc_cyc[n_rsp], lat_q[n_rsp]);
                else passed++;
                n_rsp++;
                last_rsp = cyc;
            end
            if (t_ready === 1'b1 && rq_valid === 1'b1) begin
                if (n_acc > 0) begin
                    checks++;
                    if (cyc != last_rsp + 1 || n_rsp != n_acc)
                        $display("FAIL b2b_accept%0d: at cycle %0d after %0d rsps, required cycle %0d after %0d", n_acc, cyc, n_rsp, last_rsp + 1, n_acc);
                    else passed++;
                end
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
            if (n_acc < 4) begin
                rq_write = wr_q[n_acc]; rq_addr = ad_q[n_acc]; rq_data = dt_q[n_acc];
                rq_size = sz_q[n_acc]; rq_signed = sg_q[n_acc];
            end else rq_valid = 1'b0;
        end
        rq_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (t_rspv === 1'b1) extra++;
        end
        checks++;
        if (n_rsp != 4 || n_acc != 4 || extra != 0)
            $display("FAIL b2b_count: accepted %0d responses %0d extra %0d required 4 4 0", n_acc, n_rsp, extra);
        else passed++;
    endtask

    task automatic test_reset_mid_rd();
        int unsigned waits = 0, stray = 0;
        sel = 1'b1;
        rq_write = 1'b1; rq_addr = 64'h1A; rq_data = 64'h1234; rq_size = 2'b01; rq_signed = 1'b0;
        rq_valid = 1'b1;
        while (t_ready !== 1'b1 && waits < 20) begin @(negedge clk); waits++; end
        @(negedge clk);
        rq_valid = 1'b0;
        checks++;
        if (t_mrd !== 1'b1 || t_maddr !== 64'h3)
            $display("FAIL rstrd_enter: MemoryRead=%b MemAddress=%h required 1 3", t_mrd, t_maddr);
        else passed++;
        @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        checks++;
        if ({t_ready, t_mrd, t_mwr, t_rspv, t_rsperr} !== 5'b0 || t_maddr !== '0 ||
            t_mwdata !== '0 || t_rspdata !== '0)
            $display("FAIL rstrd_clear: ready/rd/wr/rspv/err=%b%b%b%b%b addr=%h wdata=%h required all 0",
                     t_ready, t_mrd, t_mwr, t_rspv, t_rsperr, t_maddr, t_mwdata);
        else passed++;
        rst_l = 1'b1;
        @(negedge clk);
        checks++;
        if (t_ready !== 1'b1) $display("FAIL rstrd_ready: ReqReady=%b required 1", t_ready);
        else passed++;
        repeat (8) begin
            if (t_mwr === 1'b1 || t_rspv === 1'b1 || t_mrd === 1'b1) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0) $display("FAIL rstrd_dropped: %0d stray strobe/response cycles required 0", stray);
        else passed++;
        checks++;
        if (dev_dword(4'd3) !== ref_dword(4'd3))
            $display("FAIL rstrd_memory: dword3 %h required %h", dev_dword(4'd3), ref_dword(4'd3));
        else passed++;
    endtask

    initial begin
        logic [7:0] b;
        for (int unsigned i = 0; i < 128; i++) begin
            b = 8'($urandom_range(0, 255));
            ref_b[i] = b;
            dev_b[i] <= b;
        end
        for (int unsigned i = 0; i < 8; i++) begin
            ref_b[24 + i] = 8'(8'h11 * (i + 1));
            dev_b[24 + i] <= 8'(8'h11 * (i + 1));
        end
        test_reset();
        test_dword_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_random(1'b0, 40);
        test_random(1'b1, 20);
        test_back_to_back();
        test_reset_mid_rd();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1);
    end
endmodule
